// File: rtl/fc_out_serializer.sv
// Frame-parallel to serial streamer for FC neuron outputs: captures N accumulators,
// then emits one rounded, saturated WIDTH-bit activation per handshake.
module fc_out_serializer #(
  parameter int WIDTH = 8,
  parameter int N     = 84,
  parameter int ZW    = WIDTH*2 + $clog2(N),
  parameter int SHIFT = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ZW-1:0]            z [0:N-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N)-1:0]     out_idx,
  output logic                     out_last,
  output logic [$clog2(N+1)-1:0]   sat_count
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N+1);
  localparam logic signed [ZW:0] RND  = (ZW+1)'(1) << (SHIFT-1);
  localparam logic signed [ZW:0] QMAX = (ZW+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ZW:0] QMIN = -QMAX - (ZW+1)'(1);

  typedef enum logic {IDLE, SEND} state_t;
  state_t state;

  logic [ZW-1:0]  buf_q [0:N-1];
  logic [IW-1:0]  nxt_i;
  logic [WIDTH:0] beat0, beatn;   // {saturated, data}

  // One extra bit of headroom keeps the rounding add from wrapping.
  function automatic logic [WIDTH:0] requant(input logic [ZW-1:0] v);
    logic signed [ZW:0] r;
    r = ($signed({v[ZW-1], v}) + RND) >>> SHIFT;
    if (r > QMAX)      requant = {1'b1, QMAX[WIDTH-1:0]};
    else if (r < QMIN) requant = {1'b1, QMIN[WIDTH-1:0]};
    else               requant = {1'b0, r[WIDTH-1:0]};
  endfunction

  always_comb begin
    nxt_i = out_last ? '0 : out_idx + 1'b1;
    beat0 = requant(z[0]);
    beatn = requant(buf_q[nxt_i]);
  end

  // Frame store needs no reset; it is always written before being read.
  always_ff @(posedge clk)
    if (in_valid && in_ready) buf_q <= z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      sat_count <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state     <= SEND;
          in_ready  <= 1'b0;
          out_valid <= 1'b1;
          out_data  <= beat0[WIDTH-1:0];
          out_idx   <= '0;
          out_last  <= (N == 1);
          sat_count <= CW'(beat0[WIDTH]);
        end
        SEND: if (out_ready) begin
          if (out_last) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end else begin
            out_data  <= beatn[WIDTH-1:0];
            out_idx   <= nxt_i;
            out_last  <= (nxt_i == IW'(N-1));
            sat_count <= sat_count + CW'(beatn[WIDTH]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_out_serializer.sv
// Directed bench for fc_out_serializer: rounding, saturation, full-rate timing,
// backpressure, capture isolation and mid-frame reset against a requant model.
module tb_fc_out_serializer;

  localparam int WIDTH = 8;
  localparam int N     = 84;
  localparam int ZW    = WIDTH*2 + $clog2(N);
  localparam int SHIFT = 7;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [ZW-1:0]          z [0:N-1];
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [$clog2(N)-1:0]   out_idx;
  logic                   out_last;
  logic [$clog2(N+1)-1:0] sat_count;

  int n_cmp = 0;
  int n_err = 0;
  int frame [0:N-1];
  logic [WIDTH-1:0] obs [0:N-1];

  fc_out_serializer #(.WIDTH(WIDTH), .N(N), .ZW(ZW), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .z(z),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rq_raw(input int v);
    return (v + (1 << (SHIFT-1))) >>> SHIFT;
  endfunction

  function automatic bit rq_sat(input int v);
    int r = rq_raw(v);
    return (r > 127) || (r < -128);
  endfunction

  function automatic int rq(input int v);
    int r = rq_raw(v);
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r & 32'hFF;
  endfunction

  task automatic capture();
    int w = 0;
    for (int i = 0; i < N; i++) z[i] = frame[i][ZW-1:0];
    in_valid = 1'b1;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("cap_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit bp, input bit scr, input int stop_at);
    int k = 0, cyc = 0, cum = 0, cum_k;
    while (k < stop_at && cyc < 4000) begin
      cum_k = cum + (rq_sat(frame[k]) ? 1 : 0);
      chk("valid", out_valid, 1);
      chk("idx",   out_idx, k);
      chk("data",  out_data, rq(frame[k]));
      chk("last",  out_last, (k == N-1));
      chk("satc",  sat_count, cum_k);
      chk("busy",  in_ready, 0);
      obs[k] = out_data;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scr) begin
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) z[i] = ZW'($urandom);
      end
      @(posedge clk); #1; cyc++;
      if (out_ready) begin cum = cum_k; k++; end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_beats", k, stop_at);
    if (stop_at == N) begin
      chk("end_valid", out_valid, 0);
      chk("end_ready", in_ready, 1);
      chk("end_satc",  sat_count, cum);
      if (!bp) chk("period", cyc, N);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) z[i] = '0;
    #3;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_idx",   out_idx, 0);
    chk("rst_last",  out_last, 0);
    chk("rst_satc",  sat_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Rounding, full rate
    for (int i = 0; i < N; i++) frame[i] = i * 3;
    frame[0] = 191; frame[1] = 192; frame[2] = 0; frame[3] = 63;
    capture();
    drain(0, 0, N);
    chk("rnd0", obs[0], 8'd1);
    chk("rnd1", obs[1], 8'd2);
    chk("rnd2", obs[2], 8'd0);
    chk("rnd3", obs[3], 8'd0);
    chk("rnd_satc", sat_count, 0);

    // Saturation and boundaries
    for (int i = 0; i < N; i++) frame[i] = 100 - i;
    frame[5] = 16320; frame[10] = -16448; frame[20] = 20000;
    frame[40] = 16319; frame[41] = -16449;
    capture();
    drain(0, 0, N);
    chk("sat_hi",  obs[5],  8'h7F);
    chk("nsat_lo", obs[10], 8'h80);
    chk("sat_big", obs[20], 8'h7F);
    chk("nsat_hi", obs[40], 8'h7F);
    chk("sat_lo",  obs[41], 8'h80);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_satc",  sat_count, 3);
    chk("idle_valid", out_valid, 0);

    // Backpressure with random data
    for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 60000)) - 30000;
    capture();
    drain(1, 0, N);

    // Capture isolation: z churns with in_valid high during SEND
    for (int i = 0; i < N; i++) frame[i] = int'($urandom_range(0, 40000)) - 20000;
    capture();
    drain(1, 1, N);

    // Mid-frame reset at beat 40
    for (int i = 0; i < N; i++) frame[i] = (i < 5) ? 20000 : i * 5;
    capture();
    drain(0, 0, 40);
    chk("pre_rst_idx",  out_idx, 40);
    chk("pre_rst_satc", sat_count, 5);
    #2 rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_ready", in_ready, 1);
    chk("mrst_idx",   out_idx, 0);
    chk("mrst_satc",  sat_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 0);
    for (int i = 0; i < N; i++) frame[i] = (i == 60) ? -30000 : 1000 + i;
    capture();
    drain(1, 0, N);
    chk("post_rst_satc", sat_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
